// File: rtl/bamse_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bamse_irq_ctrl_pkg
// Shared definitions for the bamse interrupt controller:
//   - default port_id addresses of the controller registers
//   - handshake state encoding
//   - fixed-priority helper (lowest set index wins)
// ---------------------------------------------------------------------------
package bamse_irq_ctrl_pkg;

  // Width of the pacoblaze3 port bus (port_id, in_port, out_port).
  localparam int PORT_W = 8;

  // Default register addresses on the core port bus.
  localparam logic [PORT_W-1:0] A_PEND_DEF = 8'h20;
  localparam logic [PORT_W-1:0] A_MASK_DEF = 8'h21;
  localparam logic [PORT_W-1:0] A_VEC_DEF  = 8'h22;
  localparam logic [PORT_W-1:0] A_EOI_DEF  = 8'h23;

  // Request/ack/end-of-interrupt handshake states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  // Index of the lowest set bit; index 0 is the highest priority source.
  // Returns 0 for an all-zero request, callers gate on |req themselves.
  function automatic logic [2:0] lowest_index(input logic [7:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bamse_irq_ctrl_edge_sync.sv
// ---------------------------------------------------------------------------
// bamse_irq_ctrl_edge_sync
// Per-source front end: optional 2-flop synchroniser followed by a
// rising-edge detector producing a single-cycle pulse.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous reset, active low
//   d      in   raw interrupt source
//   rise   out  one-cycle pulse on a rising edge of the (synchronised) source
// A short arming window after reset suppresses the bogus 0->1 transition that
// the zero-reset flops would otherwise report for a source already high at
// reset release.
// ---------------------------------------------------------------------------
module bamse_irq_ctrl_edge_sync #(
  parameter bit SYNC = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  generate
    if (SYNC) begin : g_sync
      logic       meta;
      logic       stable;
      logic       prev;
      logic [2:0] arm;

      // Two-flop synchroniser, history flop for edge detection, and an arming
      // shift register that becomes valid once prev holds a real sample.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta   <= 1'b0;
          stable <= 1'b0;
          prev   <= 1'b0;
          arm    <= 3'b000;
        end else begin
          meta   <= d;
          stable <= meta;
          prev   <= stable;
          arm    <= {arm[1:0], 1'b1};
        end
      end

      assign rise = stable & ~prev & arm[2];
    end else begin : g_direct
      logic prev;
      logic arm;

      // Source is already synchronous: only the history flop and a one-cycle
      // arming delay are needed.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev <= 1'b0;
          arm  <= 1'b0;
        end else begin
          prev <= d;
          arm  <= 1'b1;
        end
      end

      assign rise = d & ~prev & arm;
    end
  endgenerate

endmodule

// File: rtl/bamse_irq_ctrl.sv
// ---------------------------------------------------------------------------
// bamse_irq_ctrl
// Interrupt controller between the bamse peripherals and the pacoblaze3 core.
// Latches rising edges of up to NSRC sources into a pending register,
// arbitrates enabled pending sources by fixed priority (index 0 highest),
// drives the core interrupt pin and sequences the ack / end-of-interrupt
// handshake. Mask, pending and vector registers sit on the core port bus.
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous reset, active low
//   src            in   interrupt sources, rising-edge sensitive
//   port_id        in   core port address
//   port_in        in   core out_port data
//   wen            in   core write_strobe
//   ren            in   core read_strobe (qualifies rd_hit only)
//   rd_data        out  read data, combinational from port_id
//   rd_hit         out  readable register addressed while ren is high
//   interrupt      out  core interrupt pin, registered
//   interrupt_ack  in   core interrupt_ack
// ---------------------------------------------------------------------------
module bamse_irq_ctrl
  import bamse_irq_ctrl_pkg::*;
#(
  parameter int               NSRC   = 8,
  parameter bit               SYNC   = 1'b1,
  parameter logic [PORT_W-1:0] A_PEND = A_PEND_DEF,
  parameter logic [PORT_W-1:0] A_MASK = A_MASK_DEF,
  parameter logic [PORT_W-1:0] A_VEC  = A_VEC_DEF,
  parameter logic [PORT_W-1:0] A_EOI  = A_EOI_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSRC-1:0]   src,
  input  logic [PORT_W-1:0] port_id,
  input  logic [PORT_W-1:0] port_in,
  input  logic              wen,
  input  logic              ren,
  output logic [PORT_W-1:0] rd_data,
  output logic              rd_hit,
  output logic              interrupt,
  input  logic              interrupt_ack
);

  logic [NSRC-1:0] src_rise;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] pend_clr;
  logic [7:0]      pend8;
  logic [7:0]      mask8;
  logic [7:0]      req8;
  logic [2:0]      vec_id;
  irq_state_t      state;
  logic            wr_pend;
  logic            wr_mask;
  logic            eoi_hit;
  logic            inserv;

  // One synchroniser / edge detector per source.
  generate
    for (genvar i = 0; i < NSRC; i++) begin : g_src
      bamse_irq_ctrl_edge_sync #(
        .SYNC (SYNC)
      ) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (src[i]),
        .rise  (src_rise[i])
      );
    end
  endgenerate

  assign wr_pend = wen && (port_id == A_PEND);
  assign wr_mask = wen && (port_id == A_MASK);
  // End-of-interrupt only counts while a request is being serviced.
  assign eoi_hit = wen && (port_id == A_EOI) && (state == ST_SERVICE);
  assign inserv  = (state == ST_ASSERT) || (state == ST_SERVICE);

  // Zero-extend the NSRC-wide registers to the 8-bit bus width so the read
  // mux and the priority encoder work for any NSRC in 1..8.
  always_comb begin
    pend8             = 8'h00;
    mask8             = 8'h00;
    pend8[NSRC-1:0]   = pend;
    mask8[NSRC-1:0]   = mask;
    req8              = pend8 & mask8;
  end

  // Pending-bit clear sources: W1C from the core and the EOI of the source
  // currently in service. Both are applied before the new edges are OR-ed in,
  // so a coincident edge always keeps its bit set.
  always_comb begin
    pend_clr = '0;
    if (wr_pend) pend_clr = port_in[NSRC-1:0];
    if (eoi_hit) begin
      for (int i = 0; i < NSRC; i++) begin
        if (vec_id == 3'(i)) pend_clr[i] = 1'b1;
      end
    end
  end

  // Pending and mask registers. Edges latch regardless of mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      mask <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | src_rise;
      if (wr_mask) mask <= port_in[NSRC-1:0];
    end
  end

  // Handshake FSM with registered interrupt pin and vector. Once a request
  // is raised it is held until acked, even if the source is masked or its
  // pending bit cleared meanwhile, so the core always sees it. vec_id only
  // changes on the IDLE->ASSERT transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      interrupt <= 1'b0;
      vec_id    <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req8) begin
            vec_id    <= lowest_index(req8);
            interrupt <= 1'b1;
            state     <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (interrupt_ack) begin
            interrupt <= 1'b0;
            state     <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (eoi_hit) state <= ST_IDLE;
        end
        default: begin
          interrupt <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Combinational read mux feeding the top-level in_port OR-mux; unmatched
  // addresses return 0 so the OR-mux is not disturbed.
  always_comb begin
    rd_data = 8'h00;
    rd_hit  = 1'b0;
    if (port_id == A_PEND) begin
      rd_data = pend8;
      rd_hit  = ren;
    end else if (port_id == A_MASK) begin
      rd_data = mask8;
      rd_hit  = ren;
    end else if (port_id == A_VEC) begin
      rd_data = {inserv, 4'b0000, vec_id};
      rd_hit  = ren;
    end
  end

endmodule
